param_icache: RTL
=================

// Module: param_icache
// PURPOSE
// - Parametrised set-associative, read-only instruction cache between fetch stage and shared AXI read port.
// - Serves 32-bit instruction words on hit.
// - On miss, fetches a full line with one AXI INCR burst, fills a victim way, then returns the word.
// - Shares the AXI read channel with the data cache via the data_cache_reading / instruction_cache_reading pair.
// - Adds over the previous generation:
//   - any SETS/WAYS/line/AXI width;
//   - per-set round-robin replacement;
//   - whole-cache invalidate;
//   - optional performance counters.
// PARAMETERS
// CACHE_LINE_SIZE  512  line size in bits; power of 2, >= AXI_DATA_WIDTH
// SETS             64   number of sets; power of 2, >= 2
// WAYS             2    associativity; power of 2, >= 1
// ADDR_WIDTH       64   address width
// DATA_WIDTH       32   word returned to fetch
// AXI_DATA_WIDTH   64   AXI rdata width; BEATS = CACHE_LINE_SIZE/AXI_DATA_WIDTH
// PORTS
// clock              in   1               system clock
// reset              in   1               synchronous, active-high reset
// read_enable        in   1               fetch request; held high until send_enable seen
// address            in   ADDR_WIDTH      byte address of instruction; bits [1:0] ignored
// invalidate_all     in   1               one-cycle pulse: clear every valid bit
// data_out           out  DATA_WIDTH      instruction word, valid while send_enable=1
// send_enable        out  1               response valid
// m_axi_arvalid      out  1               AR valid
// m_axi_araddr       out  ADDR_WIDTH      line-aligned address
// m_axi_arlen        out  8               BEATS-1
// m_axi_arsize       out  3               log2(AXI_DATA_WIDTH/8)
// m_axi_arburst      out  2               2'b01 (INCR)
// m_axi_arready      in   1               AR ready
// m_axi_rvalid       in   1               R valid
// m_axi_rlast        in   1               last beat
// m_axi_rdata        in   AXI_DATA_WIDTH  beat data; beat k fills line bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
// m_axi_rready       out  1               R ready
// data_cache_reading in   1               data cache owns the AXI read port
// instruction_cache_reading out 1         icache owns the AXI read port
// hit_count          out  32              hits since reset (see CONFIGURATION)
// miss_count         out  32              misses since reset (see CONFIGURATION)
// BEHAVIOUR
// - Address split: offset = log2(CACHE_LINE_SIZE/8) bits; index = log2(SETS) bits; tag = remainder.
// - Reset (synchronous, active-high):
//   - all valid bits, round-robin pointers and counters = 0; state = IDLE;
//   - every output = 0, except arlen/arsize/arburst, which are constants.
//   - Reset mid-burst abandons the fill; memory is reset with the same signal.
// - FSM states and transitions:
//   - IDLE: read_enable=1 and no response given since read_enable last rose.
//     - Registered tag compare; a hit asserts send_enable with the word on the next cycle, so hit latency = 1.
//     - Miss goes to MISS_REQUEST.
//   - MISS_REQUEST: instruction_cache_reading=1 only when data_cache_reading=0; otherwise wait.
//     - Then assert arvalid with araddr = address & ~(line bytes-1).
//     - Hold arvalid and araddr stable until arready; then go to MEMORY_ACCESS.
//   - MEMORY_ACCESS: rready=1; each rvalid&rready beat written at the beat counter, which then increments.
//     - Go to STORE_DATA when the beat with rlast=1 and counter == BEATS-1 is accepted.
//     - If rlast arrives early, the fill is discarded: the line is not stored and the FSM returns to MISS_REQUEST.
//   - STORE_DATA (1 cycle): victim = lowest-index invalid way, else rr_ptr[set].
//     - Write tag, data and valid=1 to the victim.
//     - If the victim was valid, rr_ptr[set] <= rr_ptr[set]+1, mod WAYS.
//     - instruction_cache_reading drops.
//   - SEND_DATA: send_enable=1 with the requested word of the filled line; hold until read_enable=0; then go to IDLE.
// - Response handshake:
//   - Exactly one response per read_enable assertion; read_enable must drop for >=1 cycle before the next request.
//   - address is sampled when the request is accepted in IDLE; changes before read_enable drops are ignored.
//   - send_enable deasserts the cycle after read_enable=0.
// - invalidate_all:
//   - In IDLE or SEND_DATA: all valid bits clear next cycle.
//   - During a miss: latched and applied in the cycle after STORE_DATA, so the just-filled line is also invalidated.
//     The pending SEND_DATA word is still delivered.
// - Simultaneous hit and invalidate_all in IDLE: the hit is served from the pre-clear state.
// CONFIGURATION
// - ICACHE_PERF_CNT_EN defined: hit_count and miss_count increment once per hit/miss response.
//   - Both saturate at 32'hFFFF_FFFF, clear on reset and are unaffected by invalidate_all.
// - ICACHE_PERF_CNT_EN undefined: hit_count = miss_count = 0 constantly; no counter flops.
// TESTING
// - Cold miss, defaults:
//   - read 0x1000 -> one AR with araddr=0x1000, arlen=7, arsize=3, arburst=1.
//   - 8 beats -> data_out = beat0[31:0]; second read of 0x1004 hits with latency 1, data = beat0[63:32].
// - Arbitration: data_cache_reading=1 during miss -> arvalid stays 0; release -> AR issued; arvalid held over 3 cycles of arready=0.
// - Replacement, WAYS=2: fill 0x0000, 0x8000 and 0x10000, all set 0.
//   - Third fill evicts way0; re-read 0x0000 misses; re-read 0x8000 hits.
// - invalidate_all during burst for 0x2000 -> word returned; next read of 0x2000 misses and issues new AR.
// - Early rlast on beat 5 -> no store, AR reissued.
//   - Reset asserted mid-burst -> all outputs 0 next cycle; next read misses.
// - With ICACHE_PERF_CNT_EN: 1 miss + 3 hits -> miss_count=1, hit_count=3; without it both read 0.

Source files
------------

// File: rtl/param_icache.sv
// param_icache: set-associative read-only instruction cache.
// A miss fetches a whole line with one AXI INCR burst and fills a victim way.
// The victim is the lowest-index invalid way; when the set is full, a per-set
// round-robin pointer picks the victim.
// Optional feature macro: ICACHE_PERF_CNT_EN enables saturating hit/miss counters.
//
// state         | meaning
// IDLE          | waiting for read_enable; tag compare happens here
// MISS_REQUEST  | win the shared AXI read port, then issue AR
// MEMORY_ACCESS | accept R beats into the line buffer
// STORE_DATA    | write the line buffer into the victim way
// SEND_DATA     | present the word until read_enable drops
module param_icache #(
    parameter int CACHE_LINE_SIZE = 512,
    parameter int SETS            = 64,
    parameter int WAYS            = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 32,
    parameter int AXI_DATA_WIDTH  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      read_enable,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic                      invalidate_all,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      send_enable,
    output logic                      m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    input  logic                      m_axi_arready,
    input  logic                      m_axi_rvalid,
    input  logic                      m_axi_rlast,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    output logic                      m_axi_rready,
    input  logic                      data_cache_reading,
    output logic                      instruction_cache_reading,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
);
    localparam int OFF_W    = $clog2(CACHE_LINE_SIZE / 8);
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_W    = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int BEATS    = CACHE_LINE_SIZE / AXI_DATA_WIDTH;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_LSB = $clog2(DATA_WIDTH / 8);
    localparam int WSEL_W   = OFF_W - WORD_LSB;

    typedef enum logic [2:0] {
        IDLE, MISS_REQUEST, MEMORY_ACCESS, STORE_DATA, SEND_DATA
    } state_t;

    state_t r_state, w_next;

    logic [WAYS-1:0]            r_valid [SETS];
    logic [TAG_W-1:0]           r_tag   [SETS][WAYS];
    logic [CACHE_LINE_SIZE-1:0] r_data  [SETS][WAYS];
    logic [WAY_W-1:0]           r_rr    [SETS];

    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [CACHE_LINE_SIZE-1:0] r_line;
    logic [BEAT_W-1:0]          r_beat;
    logic                       r_ic_reading;
    logic                       r_inv_pend;
    logic [DATA_WIDTH-1:0]      r_data_out;

    logic [IDX_W-1:0]      w_in_idx, w_idx;
    logic [TAG_W-1:0]      w_in_tag, w_tag;
    logic [WSEL_W-1:0]     w_in_wsel, w_wsel;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hit_word;
    logic [WAY_W-1:0]      w_victim;
    logic                  w_all_valid;
    logic                  w_req, w_beat_ok, w_last_ok, w_early, w_clear;
    logic                  w_unused;

    assign w_in_idx  = address[OFF_W +: IDX_W];
    assign w_in_tag  = address[ADDR_WIDTH-1 -: TAG_W];
    assign w_in_wsel = address[WORD_LSB +: WSEL_W];
    assign w_idx     = r_addr[OFF_W +: IDX_W];
    assign w_tag     = r_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_wsel    = r_addr[WORD_LSB +: WSEL_W];
    assign w_unused  = &{1'b0, address[WORD_LSB-1:0], r_addr[WORD_LSB-1:0]};

    assign w_req       = (r_state == IDLE) && read_enable;
    assign w_beat_ok   = (r_state == MEMORY_ACCESS) && m_axi_rvalid;
    assign w_last_ok   = w_beat_ok && m_axi_rlast && (r_beat == BEAT_W'(BEATS - 1));
    assign w_early     = w_beat_ok && m_axi_rlast && (r_beat != BEAT_W'(BEATS - 1));
    assign w_all_valid = &r_valid[w_idx];
    // A deferred invalidate lands in the first SEND_DATA cycle, after the fill was written.
    assign w_clear     = (invalidate_all && (r_state == IDLE || r_state == SEND_DATA))
                       || (r_inv_pend && r_state == SEND_DATA);

    // Tag compare of the incoming address against every way of its set.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_in_idx][w] && r_tag[w_in_idx][w] == w_in_tag) begin
                w_hit      = 1'b1;
                w_hit_word = r_data[w_in_idx][w][w_in_wsel*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Victim choice: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        w_victim = r_rr[w_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:          if (read_enable) w_next = w_hit ? SEND_DATA : MISS_REQUEST;
            MISS_REQUEST:  if (r_ic_reading && m_axi_arready) w_next = MEMORY_ACCESS;
            MEMORY_ACCESS: begin
                if (w_last_ok)    w_next = STORE_DATA;
                else if (w_early) w_next = MISS_REQUEST;
            end
            STORE_DATA:    w_next = SEND_DATA;
            SEND_DATA:     if (!read_enable) w_next = IDLE;
            default:       w_next = IDLE;
        endcase
    end

    // Outputs decoded from state plus the datapath registers.
    always_comb begin
        send_enable               = (r_state == SEND_DATA);
        m_axi_arvalid             = (r_state == MISS_REQUEST) && r_ic_reading;
        m_axi_rready              = (r_state == MEMORY_ACCESS);
        instruction_cache_reading = r_ic_reading;
        data_out                  = r_data_out;
        m_axi_araddr              = {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        m_axi_arlen               = 8'(BEATS - 1);
        m_axi_arsize              = 3'($clog2(AXI_DATA_WIDTH / 8));
        m_axi_arburst             = 2'b01;
    end

    // Request capture, port ownership, beat assembly and response word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr       <= '0;
            r_line       <= '0;
            r_beat       <= '0;
            r_ic_reading <= 1'b0;
            r_inv_pend   <= 1'b0;
            r_data_out   <= '0;
        end else begin
            if (w_req) begin
                r_addr <= address;
                if (w_hit) r_data_out <= w_hit_word;
            end
            if (r_state == MISS_REQUEST) begin
                r_beat <= '0;
                if (!r_ic_reading && !data_cache_reading) r_ic_reading <= 1'b1;
            end
            if (w_beat_ok) begin
                r_line[r_beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= m_axi_rdata;
                r_beat <= w_early ? '0 : r_beat + 1'b1;
                if (w_last_ok) r_ic_reading <= 1'b0;
            end
            if (r_state == STORE_DATA) r_data_out <= r_line[w_wsel*DATA_WIDTH +: DATA_WIDTH];
            if (invalidate_all && (r_state == MISS_REQUEST || r_state == MEMORY_ACCESS
                                   || r_state == STORE_DATA))
                r_inv_pend <= 1'b1;
            else if (r_state == SEND_DATA)
                r_inv_pend <= 1'b0;
        end
    end

    // Valid bits and replacement pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            if (r_state == STORE_DATA) begin
                r_valid[w_idx][w_victim] <= 1'b1;
                if (w_all_valid) r_rr[w_idx] <= (WAYS > 1) ? r_rr[w_idx] + 1'b1 : '0;
            end
            if (w_clear) begin
                for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
            end
        end
    end

    // Tag and line storage; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clock) begin
        if (r_state == STORE_DATA) begin
            r_tag[w_idx][w_victim]  <= w_tag;
            r_data[w_idx][w_victim] <= r_line;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    // Saturating hit/miss counters, one step per accepted request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_req) begin
            if (w_hit && r_hit_cnt != 32'hFFFF_FFFF)   r_hit_cnt  <= r_hit_cnt + 1'b1;
            if (!w_hit && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
